// File: rtl/modrm_encode_pkg.sv
// Shared CPU addressing-mode definitions: ModR/M MOD field, base/index selectors and R/M codes.
// Also used by the ModR/M decoder, so RM code values must stay architectural.
package modrm_encode_pkg;

  typedef enum logic [1:0] {
    MOD_NODISP = 2'b00,
    MOD_DISP8  = 2'b01,
    MOD_DISP16 = 2'b10,
    MOD_REG    = 2'b11
  } mod_e;

  typedef enum logic [1:0] {
    BASE_NONE = 2'd0,
    BASE_BX   = 2'd1,
    BASE_BP   = 2'd2,
    BASE_RSVD = 2'd3
  } base_sel_e;

  typedef enum logic [1:0] {
    INDEX_NONE = 2'd0,
    INDEX_SI   = 2'd1,
    INDEX_DI   = 2'd2,
    INDEX_RSVD = 2'd3
  } index_sel_e;

  localparam logic [2:0] RM_BX_SI  = 3'b000;
  localparam logic [2:0] RM_BX_DI  = 3'b001;
  localparam logic [2:0] RM_BP_SI  = 3'b010;
  localparam logic [2:0] RM_BP_DI  = 3'b011;
  localparam logic [2:0] RM_SI     = 3'b100;
  localparam logic [2:0] RM_DI     = 3'b101;
  localparam logic [2:0] RM_BP     = 3'b110;
  localparam logic [2:0] RM_DIRECT = 3'b110;
  localparam logic [2:0] RM_BX     = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MODRM,
    ST_DISP_LO,
    ST_DISP_HI
  } enc_state_e;

  typedef struct packed {
    mod_e       mod;
    logic [2:0] rm;
    logic [1:0] disp_bytes;
    logic       bp_as_base;
  } mode_t;

  // True when the 16-bit displacement survives truncation to a sign-extended disp8.
  function automatic logic fits_disp8(input logic [15:0] d);
    return (d[15:7] == 9'h000) || (d[15:7] == 9'h1FF);
  endfunction

endpackage

// File: rtl/modrm_encode_if.sv
// Request port and encoded byte stream of the ModR/M encoder.
// master = request source / byte consumer, slave = encoder.
interface modrm_encode_if;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_regnum;
  logic        req_rm_is_reg;
  logic [2:0]  req_rm_regnum;
  logic [1:0]  req_base;
  logic [1:0]  req_index;
  logic [15:0] req_displacement;
  logic        byte_valid;
  logic        byte_ready;
  logic [7:0]  byte_data;
  logic        byte_last;
  logic        bp_as_base;
  logic [1:0]  disp_bytes;

  modport master (
    output req_valid, req_regnum, req_rm_is_reg, req_rm_regnum, req_base, req_index,
           req_displacement, byte_ready,
    input  req_ready, byte_valid, byte_data, byte_last, bp_as_base, disp_bytes
  );

  modport slave (
    input  req_valid, req_regnum, req_rm_is_reg, req_rm_regnum, req_base, req_index,
           req_displacement, byte_ready,
    output req_ready, byte_valid, byte_data, byte_last, bp_as_base, disp_bytes
  );
endinterface

// File: rtl/modrm_encode_mode_select.sv
// Combinational addressing-mode selection: request fields -> MOD, RM, displacement size, BP-base flag.
// Reserved base/index codes behave as "none".
module modrm_mode_select
  import modrm_encode_pkg::*;
(
  input  logic        rm_is_reg,
  input  logic [2:0]  rm_regnum,
  input  logic [1:0]  base,
  input  logic [1:0]  index,
  input  logic [15:0] displacement,
  output mode_t       mode
);

  base_sel_e  base_sel;
  index_sel_e index_sel;
  logic [2:0] mem_rm;
  logic       direct;
  logic       bp_alone;

  always_comb begin
    base_sel  = base_sel_e'(base);
    index_sel = index_sel_e'(index);
    if (base_sel == BASE_RSVD)
      base_sel = BASE_NONE;
    if (index_sel == INDEX_RSVD)
      index_sel = INDEX_NONE;

    case (base_sel)
      BASE_BX: mem_rm = (index_sel == INDEX_SI) ? RM_BX_SI :
                        (index_sel == INDEX_DI) ? RM_BX_DI : RM_BX;
      BASE_BP: mem_rm = (index_sel == INDEX_SI) ? RM_BP_SI :
                        (index_sel == INDEX_DI) ? RM_BP_DI : RM_BP;
      default: mem_rm = (index_sel == INDEX_SI) ? RM_SI :
                        (index_sel == INDEX_DI) ? RM_DI : RM_DIRECT;
    endcase

    direct   = (base_sel == BASE_NONE) && (index_sel == INDEX_NONE);
    // RM=110 with MOD=00 means direct, so BP alone always needs a displacement byte.
    bp_alone = (base_sel == BASE_BP) && (index_sel == INDEX_NONE);

    mode = '0;
    if (rm_is_reg) begin
      mode.mod = MOD_REG;
      mode.rm  = rm_regnum;
    end else if (direct) begin
      mode.mod        = MOD_NODISP;
      mode.rm         = RM_DIRECT;
      mode.disp_bytes = 2'd2;
    end else begin
      mode.rm = mem_rm;
      if (displacement == 16'h0000 && !bp_alone) begin
        mode.mod        = MOD_NODISP;
        mode.disp_bytes = 2'd0;
      end else if (fits_disp8(displacement)) begin
        mode.mod        = MOD_DISP8;
        mode.disp_bytes = 2'd1;
      end else begin
        mode.mod        = MOD_DISP16;
        mode.disp_bytes = 2'd2;
      end
    end

    // Register operands never address memory, so they never imply an SS segment.
    mode.bp_as_base = (mode.mod != MOD_REG) &&
                      ((mode.rm == RM_BP_SI) || (mode.rm == RM_BP_DI) ||
                       ((mode.rm == RM_BP) && (mode.mod != MOD_NODISP)));
  end

endmodule

// File: rtl/modrm_encode.sv
// ModR/M encoder: latches one request, then streams ModR/M plus 0-2 displacement bytes, one per handshake.
// First byte valid the cycle after acceptance; outputs hold under byte_ready=0, no new request until done.
module modrm_encode
  import modrm_encode_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  modrm_encode_if.slave bus
);

  mode_t       next_mode;
  enc_state_e  state;
  logic [15:0] disp_q;
  logic        byte_fire;

  modrm_mode_select u_mode_select (
    .rm_is_reg    (bus.req_rm_is_reg),
    .rm_regnum    (bus.req_rm_regnum),
    .base         (bus.req_base),
    .index        (bus.req_index),
    .displacement (bus.req_displacement),
    .mode         (next_mode)
  );

  assign byte_fire = bus.byte_valid && bus.byte_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_IDLE;
      disp_q         <= 16'h0000;
      bus.req_ready  <= 1'b1;
      bus.byte_valid <= 1'b0;
      bus.byte_data  <= 8'h00;
      bus.byte_last  <= 1'b0;
      bus.bp_as_base <= 1'b0;
      bus.disp_bytes <= 2'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.req_valid && bus.req_ready) begin
            state          <= ST_MODRM;
            disp_q         <= bus.req_displacement;
            bus.req_ready  <= 1'b0;
            bus.byte_valid <= 1'b1;
            bus.byte_data  <= {next_mode.mod, bus.req_regnum, next_mode.rm};
            bus.byte_last  <= (next_mode.disp_bytes == 2'd0);
            bus.bp_as_base <= next_mode.bp_as_base;
            bus.disp_bytes <= next_mode.disp_bytes;
          end
        end
        default: begin
          if (byte_fire) begin
            if (bus.byte_last) begin
              state          <= ST_IDLE;
              bus.req_ready  <= 1'b1;
              bus.byte_valid <= 1'b0;
              bus.byte_data  <= 8'h00;
              bus.byte_last  <= 1'b0;
              bus.bp_as_base <= 1'b0;
              bus.disp_bytes <= 2'd0;
            end else if (state == ST_MODRM) begin
              state         <= ST_DISP_LO;
              bus.byte_data <= disp_q[7:0];
              bus.byte_last <= (bus.disp_bytes == 2'd1);
            end else begin
              state         <= ST_DISP_HI;
              bus.byte_data <= disp_q[15:8];
              bus.byte_last <= 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: doc/modrm_encode.md
# modrm_encode

Encodes an x86 16-bit addressing-mode request (REG field, register-or-memory operand, base/index selection, displacement) into its ModR/M byte plus 0–2 displacement bytes. Emits them one byte per cycle on a valid/ready byte stream. It is the inverse of the CPU's ModR/M decoder and sits in the instruction-injection path (self-test sequencer, debug instruction builder), feeding the prefetch/instruction byte queue.

## Interface
No parameters.
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- req_valid  in  1  request offered
- req_ready  out  1  block can accept a request (IDLE only)
- req_regnum  in  3  REG field value
- req_rm_is_reg  in  1  1 = register operand (MOD=11)
- req_rm_regnum  in  3  R/M register number when req_rm_is_reg
- req_base  in  2  0 none, 1 BX, 2 BP, 3 reserved (treated as none)
- req_index  in  2  0 none, 1 SI, 2 DI, 3 reserved (treated as none)
- req_displacement  in  16  displacement value
- byte_valid  out  1  byte_data is valid
- byte_ready  in  1  consumer accepts the byte
- byte_data  out  8  encoded byte
- byte_last  out  1  current byte is the final byte of this encoding
- bp_as_base  out  1  latched: the encoded mode uses BP as base (SS-default); valid while busy
- disp_bytes  out  2  latched: number of displacement bytes (0/1/2); valid while busy

## Operation
- Mode selection, evaluated when a request is accepted:
  - If req_rm_is_reg: MOD=11, RM=req_rm_regnum, 0 disp bytes; displacement ignored.
  - Otherwise RM comes from {base,index}:
    - BX+SI=000, BX+DI=001, BP+SI=010, BP+DI=011
    - SI=100, DI=101, BP=110, BX=111
    - none/none = direct: MOD=00, RM=110, 2 disp bytes.
  - Displacement size, non-direct memory modes:
    - disp==0 and mode is not BP-alone → MOD=00, 0 bytes.
    - disp[15:7] all equal (sign-extendable) → MOD=01, 1 byte (disp[7:0]).
    - Otherwise → MOD=10, 2 bytes, low byte first.
  - BP-alone with disp==0 → MOD=01, disp8=0x00.
- ModR/M byte = {MOD, req_regnum, RM}.
- bp_as_base=1 for RM 010, 011, and 110 with MOD≠00.
- FSM states: IDLE → MODRM → (DISP_LO → (DISP_HI)) → IDLE.
  - Each state advances only on byte_valid && byte_ready.
  - byte_last is high in the final state of the sequence.
- All request fields are latched at acceptance; later input changes have no effect.

## Timing
- Reset values: req_ready=1 (once reset deasserts), byte_valid=0, byte_data=0, byte_last=0, bp_as_base=0, disp_bytes=0, state IDLE.
- Request is accepted at the clock edge where req_valid && req_ready. byte_valid rises the next cycle.
- One byte per cycle under continuous byte_ready:
  - a 3-byte encoding occupies 3 cycles;
  - req_ready returns to 1 in the cycle after the last handshake.
- No overlap: req_ready=0 from acceptance until return to IDLE.
- Backpressure: while byte_ready=0, byte_data and byte_last hold stable and byte_valid stays 1. byte_valid never drops without a handshake.
- Reset mid-sequence: the next cycle is IDLE, all outputs return to reset values, and the partial encoding is discarded with no further bytes.
- Registered outputs only; no combinational path from req_* or byte_ready to byte_*.

## Structure
- The shared CPU package holds:
  - typedefs for the MOD enum (MOD_NODISP, MOD_DISP8, MOD_DISP16, MOD_REG) and the base/index selector enums;
  - the RM code constants, which are also used by the decoder.
- One combinational sub-module, modrm_mode_select: request fields → {mod, rm, disp_bytes, bp_as_base}.
- The top level holds the FSM and the output registers.

## Test plan
- rm_is_reg=1, regnum=2, rm_regnum=3 → single byte 0xD3, byte_last=1, disp_bytes=0.
- base=BX, index=SI, disp=0x0000 → 0x00 only. base=BP, index=none, disp=0 → 0x46, 0x00 (last), bp_as_base=1.
- base=BX, index=SI, disp=0x0010 → 0x40, 0x10. disp=0xFF80 → 0x40, 0x80 (sign-extended disp8).
- base=BP, index=DI, disp=0x2000 → 0x83, 0x00, 0x20, bp_as_base=1. base=none, index=none, regnum=0, disp=0x1234 → 0x06, 0x34, 0x12, bp_as_base=0.
- Backpressure: hold byte_ready=0 for 4 cycles on each byte of the 0x83 case → bytes are stable, none are lost or duplicated, and req_ready stays 0 throughout.
- Reset asserted after the first byte of the direct case → next cycle byte_valid=0 and req_ready=1; a following request encodes correctly.
